id_exe_pipe_reg: RTL and testbench

//  Parametrised ID->EXE pipeline register with valid/ready handshake and 2-entry skid storage.

---
 rtl/andes_pipe_pkg.sv | 32 +++
 rtl/pipe_skid_buf.sv | 96 +++++++++
 rtl/id_exe_pipe_reg.sv | 170 +++++++++++++++++
 tb/tb_id_exe_pipe_reg.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/andes_pipe_pkg.sv
// Types and constants shared by the andes stage registers.
package andes_pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

  localparam int unsigned ALU_NOP = 0;
  localparam logic        REG_SRC = 1'b0;

  typedef struct packed {
    logic lwsrc;
    logic aluSrc2;
    logic dm_read;
    logic dm_write;
    logic reg_we;
  } ctrl_t;

  // Control word that makes an empty EXE slot architecturally harmless.
  function automatic ctrl_t bubble_ctrl();
    ctrl_t c;
    c.lwsrc    = 1'b0;
    c.aluSrc2  = REG_SRC;
    c.dm_read  = 1'b0;
    c.dm_write = 1'b0;
    c.reg_we   = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid register with flush; the low KEY_W bits of
// the skid entry are exposed so the owner can hazard-check it.
module pipe_skid_buf
  import andes_pipe_pkg::*;
#(
  parameter type T     = logic [7:0],
  parameter int  KEY_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  input  logic             i_in_block,
  input  T                 i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output T                 o_out_data,
  output logic             o_skid_valid,
  output logic [KEY_W-1:0] o_skid_key
);

  occ_e r_state;
  occ_e w_state_nxt;
  T     r_main;
  T     r_skid;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_main_ld;
  logic w_main_from_skid;
  logic w_skid_ld;

  assign o_out_valid  = (r_state != OCC_EMPTY);
  assign o_skid_valid = (r_state == OCC_SKID);
  assign o_in_ready   = i_rst && !o_skid_valid && !i_in_block;
  assign o_out_data   = r_main;
  assign o_skid_key   = r_skid[KEY_W-1:0];
  assign w_in_xfer    = i_in_valid && o_in_ready;
  assign w_out_xfer   = o_out_valid && i_out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_in_xfer) begin
          w_main_ld   = 1'b1;
          w_state_nxt = OCC_FULL;
        end
      end
      OCC_FULL: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_ld = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = OCC_EMPTY;
        end else if (w_in_xfer) begin
          w_skid_ld   = 1'b1;
          w_state_nxt = OCC_SKID;
        end
      end
      OCC_SKID: begin
        if (w_out_xfer) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = OCC_FULL;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
    // A kill drops both held entries and anything offered this cycle.
    if (i_flush) begin
      w_state_nxt      = OCC_EMPTY;
      w_main_ld        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= OCC_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_ld)             r_main <= i_in_data;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_skid_ld)             r_skid <= i_in_data;
    end
  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register: skid-buffered handshake, load-use stall with
// bubble insertion, bubble-safe control outputs and a saturating stall counter.
module id_exe_pipe_reg
  import andes_pipe_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RIDX_W    = 5,
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_id_valid,
  output logic                 o_id_ready,
  input  logic [ADDR_W-1:0]    i_id_pc,
  input  logic [ADDR_W-1:0]    i_id_branch_addr,
  input  logic [DATA_W-1:0]    i_id_reg1,
  input  logic [DATA_W-1:0]    i_id_reg2,
  input  logic [DATA_W-1:0]    i_id_write,
  input  logic [RIDX_W-1:0]    i_id_rs1,
  input  logic [RIDX_W-1:0]    i_id_rs2,
  input  logic [RIDX_W-1:0]    i_id_rd,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  input  logic [ALUCTRL_W-1:0] i_id_alu_ctrl,
  input  logic                 i_id_lwsrc,
  input  logic                 i_id_aluSrc2,
  input  logic                 i_id_DM_read,
  input  logic                 i_id_DM_write,
  input  logic                 i_id_reg_we,
  output logic                 o_exe_valid,
  input  logic                 i_exe_ready,
  output logic [ADDR_W-1:0]    o_exe_pc,
  output logic [ADDR_W-1:0]    o_exe_branch_addr,
  output logic [DATA_W-1:0]    o_exe_reg1,
  output logic [DATA_W-1:0]    o_exe_reg2,
  output logic [DATA_W-1:0]    o_exe_write,
  output logic [RIDX_W-1:0]    o_exe_rs1,
  output logic [RIDX_W-1:0]    o_exe_rs2,
  output logic [RIDX_W-1:0]    o_exe_rd,
  output logic [ALUCTRL_W-1:0] o_exe_alu_ctrl,
  output logic                 o_exe_lwsrc,
  output logic                 o_exe_aluSrc2,
  output logic                 o_exe_DM_read,
  output logic                 o_exe_DM_write,
  output logic                 o_exe_reg_we,
  output logic                 o_hazard_stall,
  output logic [CNT_W-1:0]     o_bubble_cnt
);

  // rd and dm_read sit at the LSB end so the skid buffer can expose them as a key.
  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    branch_addr;
    logic [DATA_W-1:0]    reg1;
    logic [DATA_W-1:0]    reg2;
    logic [DATA_W-1:0]    wdata;
    logic [RIDX_W-1:0]    rs1;
    logic [RIDX_W-1:0]    rs2;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 lwsrc;
    logic                 aluSrc2;
    logic                 dm_write;
    logic                 reg_we;
    logic [RIDX_W-1:0]    rd;
    logic                 dm_read;
  } id_exe_pkt_t;

  localparam int               KEY_W   = RIDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic load_use(
    input logic              v,
    input logic              dm_read,
    input logic [RIDX_W-1:0] rd,
    input logic              rs1_used,
    input logic [RIDX_W-1:0] rs1,
    input logic              rs2_used,
    input logic [RIDX_W-1:0] rs2
  );
    return v && dm_read && (rd != '0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

  id_exe_pkt_t      w_id_pkt;
  id_exe_pkt_t      w_main;
  logic             w_main_valid;
  logic             w_skid_valid;
  logic [KEY_W-1:0] w_skid_key;
  logic             w_hazard;
  ctrl_t            w_exe_ctrl;
  logic [CNT_W-1:0] r_bubble_cnt;

  assign w_id_pkt.pc          = i_id_pc;
  assign w_id_pkt.branch_addr = i_id_branch_addr;
  assign w_id_pkt.reg1        = i_id_reg1;
  assign w_id_pkt.reg2        = i_id_reg2;
  assign w_id_pkt.wdata       = i_id_write;
  assign w_id_pkt.rs1         = i_id_rs1;
  assign w_id_pkt.rs2         = i_id_rs2;
  assign w_id_pkt.alu_ctrl    = i_id_alu_ctrl;
  assign w_id_pkt.lwsrc       = i_id_lwsrc;
  assign w_id_pkt.aluSrc2     = i_id_aluSrc2;
  assign w_id_pkt.dm_write    = i_id_DM_write;
  assign w_id_pkt.reg_we      = i_id_reg_we;
  assign w_id_pkt.rd          = i_id_rd;
  assign w_id_pkt.dm_read     = i_id_DM_read;

  // ID -> EXE register boundary.
  pipe_skid_buf #(
    .T     (id_exe_pkt_t),
    .KEY_W (KEY_W)
  ) u_skid (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_in_valid   (i_id_valid),
    .i_in_block   (w_hazard),
    .i_in_data    (w_id_pkt),
    .o_in_ready   (o_id_ready),
    .o_out_valid  (w_main_valid),
    .i_out_ready  (i_exe_ready),
    .o_out_data   (w_main),
    .o_skid_valid (w_skid_valid),
    .o_skid_key   (w_skid_key)
  );

  assign w_hazard = i_rst && i_id_valid && !i_flush &&
                    (load_use(w_main_valid, w_main.dm_read, w_main.rd,
                              i_id_rs1_used, i_id_rs1, i_id_rs2_used, i_id_rs2) ||
                     load_use(w_skid_valid, w_skid_key[0], w_skid_key[KEY_W-1:1],
                              i_id_rs1_used, i_id_rs1, i_id_rs2_used, i_id_rs2));

  always_ff @(posedge i_clk) begin
    if (!i_rst)                                     r_bubble_cnt <= '0;
    else if (w_hazard && (r_bubble_cnt != CNT_MAX)) r_bubble_cnt <= r_bubble_cnt + 1'b1;
  end

  always_comb begin
    w_exe_ctrl = bubble_ctrl();
    if (w_main_valid) begin
      w_exe_ctrl.lwsrc    = w_main.lwsrc;
      w_exe_ctrl.aluSrc2  = w_main.aluSrc2;
      w_exe_ctrl.dm_read  = w_main.dm_read;
      w_exe_ctrl.dm_write = w_main.dm_write;
      w_exe_ctrl.reg_we   = w_main.reg_we;
    end
  end

  assign o_exe_valid       = w_main_valid;
  assign o_exe_pc          = w_main.pc;
  assign o_exe_branch_addr = w_main.branch_addr;
  assign o_exe_reg1        = w_main.reg1;
  assign o_exe_reg2        = w_main.reg2;
  assign o_exe_write       = w_main.wdata;
  assign o_exe_rs1         = w_main.rs1;
  assign o_exe_rs2         = w_main.rs2;
  assign o_exe_rd          = w_main.rd;
  assign o_exe_alu_ctrl    = w_main_valid ? w_main.alu_ctrl : ALUCTRL_W'(ALU_NOP);
  assign o_exe_lwsrc       = w_exe_ctrl.lwsrc;
  assign o_exe_aluSrc2     = w_exe_ctrl.aluSrc2;
  assign o_exe_DM_read     = w_exe_ctrl.dm_read;
  assign o_exe_DM_write    = w_exe_ctrl.dm_write;
  assign o_exe_reg_we      = w_exe_ctrl.reg_we;
  assign o_hazard_stall    = w_hazard;
  assign o_bubble_cnt      = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg: stream, backpressure, load-use, flush, reset, saturation.
module tb_id_exe_pipe_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_branch_addr, id_reg1, id_reg2, id_write;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic [3:0]  id_alu_ctrl;
  logic        id_lwsrc, id_aluSrc2, id_DM_read, id_DM_write, id_reg_we;
  logic        exe_valid, exe_ready;
  logic [31:0] exe_pc, exe_branch_addr, exe_reg1, exe_reg2, exe_write;
  logic [4:0]  exe_rs1, exe_rs2, exe_rd;
  logic [3:0]  exe_alu_ctrl;
  logic        exe_lwsrc, exe_aluSrc2, exe_DM_read, exe_DM_write, exe_reg_we;
  logic        hazard_stall;
  logic [15:0] bubble_cnt;

  logic        s_id_ready, s_exe_valid;
  logic [31:0] s_exe_pc, s_exe_branch_addr, s_exe_reg1, s_exe_reg2, s_exe_write;
  logic [4:0]  s_exe_rs1, s_exe_rs2, s_exe_rd;
  logic [3:0]  s_exe_alu_ctrl;
  logic        s_exe_lwsrc, s_exe_aluSrc2, s_exe_DM_read, s_exe_DM_write, s_exe_reg_we;
  logic        s_hazard_stall;
  logic [1:0]  s_bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  id_exe_pipe_reg dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_id_valid(id_valid), .o_id_ready(id_ready),
    .i_id_pc(id_pc), .i_id_branch_addr(id_branch_addr),
    .i_id_reg1(id_reg1), .i_id_reg2(id_reg2), .i_id_write(id_write),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_id_alu_ctrl(id_alu_ctrl), .i_id_lwsrc(id_lwsrc), .i_id_aluSrc2(id_aluSrc2),
    .i_id_DM_read(id_DM_read), .i_id_DM_write(id_DM_write), .i_id_reg_we(id_reg_we),
    .o_exe_valid(exe_valid), .i_exe_ready(exe_ready),
    .o_exe_pc(exe_pc), .o_exe_branch_addr(exe_branch_addr),
    .o_exe_reg1(exe_reg1), .o_exe_reg2(exe_reg2), .o_exe_write(exe_write),
    .o_exe_rs1(exe_rs1), .o_exe_rs2(exe_rs2), .o_exe_rd(exe_rd),
    .o_exe_alu_ctrl(exe_alu_ctrl), .o_exe_lwsrc(exe_lwsrc), .o_exe_aluSrc2(exe_aluSrc2),
    .o_exe_DM_read(exe_DM_read), .o_exe_DM_write(exe_DM_write), .o_exe_reg_we(exe_reg_we),
    .o_hazard_stall(hazard_stall), .o_bubble_cnt(bubble_cnt)
  );

  id_exe_pipe_reg #(.CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_id_valid(id_valid), .o_id_ready(s_id_ready),
    .i_id_pc(id_pc), .i_id_branch_addr(id_branch_addr),
    .i_id_reg1(id_reg1), .i_id_reg2(id_reg2), .i_id_write(id_write),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_id_alu_ctrl(id_alu_ctrl), .i_id_lwsrc(id_lwsrc), .i_id_aluSrc2(id_aluSrc2),
    .i_id_DM_read(id_DM_read), .i_id_DM_write(id_DM_write), .i_id_reg_we(id_reg_we),
    .o_exe_valid(s_exe_valid), .i_exe_ready(exe_ready),
    .o_exe_pc(s_exe_pc), .o_exe_branch_addr(s_exe_branch_addr),
    .o_exe_reg1(s_exe_reg1), .o_exe_reg2(s_exe_reg2), .o_exe_write(s_exe_write),
    .o_exe_rs1(s_exe_rs1), .o_exe_rs2(s_exe_rs2), .o_exe_rd(s_exe_rd),
    .o_exe_alu_ctrl(s_exe_alu_ctrl), .o_exe_lwsrc(s_exe_lwsrc), .o_exe_aluSrc2(s_exe_aluSrc2),
    .o_exe_DM_read(s_exe_DM_read), .o_exe_DM_write(s_exe_DM_write), .o_exe_reg_we(s_exe_reg_we),
    .o_hazard_stall(s_hazard_stall), .o_bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic dmr);
    id_valid       = v;
    id_pc          = pc;
    id_branch_addr = pc + 32'h100;
    id_reg1        = pc ^ 32'hA5A5_0000;
    id_reg2        = pc + 32'h1;
    id_write       = pc + 32'h2;
    id_rs1         = rs1;
    id_rs1_used    = u1;
    id_rs2         = rs2;
    id_rs2_used    = u2;
    id_rd          = rd;
    id_alu_ctrl    = 4'h3;
    id_lwsrc       = dmr;
    id_aluSrc2     = 1'b1;
    id_DM_read     = dmr;
    id_DM_write    = ~dmr;
    id_reg_we      = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; exe_ready = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); tick();

    // reset state
    offer(1'b1, 32'h40, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    #1;
    check_vec("rst_id_ready", id_ready, 0);
    check_vec("rst_exe_valid", exe_valid, 0);
    check_vec("rst_bubble_cnt", bubble_cnt, 0);
    check_vec("rst_exe_pc", exe_pc, 0);
    check_vec("rst_alu_nop", exe_alu_ctrl, 0);
    check_vec("rst_aluSrc2", exe_aluSrc2, 0);
    check_vec("rst_reg_we", exe_reg_we, 0);
    rst = 1'b1;
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check_vec("rst_rel_id_ready", id_ready, 1);

    // stream
    exe_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 32'(i * 4), 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
      #1;
      check_vec("stream_id_ready", id_ready, 1);
      tick();
      check_vec("stream_exe_valid", exe_valid, 1);
      check_vec("stream_exe_pc", exe_pc, 32'(i * 4));
    end
    check_vec("stream_alu_ctrl", exe_alu_ctrl, 4'h3);
    check_vec("stream_reg2", exe_reg2, 32'h1D);
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check_vec("drain_exe_valid", exe_valid, 0);
    check_vec("drain_alu_nop", exe_alu_ctrl, 0);
    check_vec("drain_aluSrc2", exe_aluSrc2, 0);
    check_vec("drain_pc_hold", exe_pc, 32'h1C);

    // backpressure
    exe_ready = 1'b0;
    offer(1'b1, 32'h100, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    tick();
    check_vec("bp_id_ready_c1", id_ready, 1);
    offer(1'b1, 32'h104, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    tick();
    check_vec("bp_id_ready_c2", id_ready, 0);
    check_vec("bp_pc_c2", exe_pc, 32'h100);
    offer(1'b1, 32'h108, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    tick();
    check_vec("bp_id_ready_c3", id_ready, 0);
    check_vec("bp_pc_c3", exe_pc, 32'h100);
    check_vec("bp_valid_c3", exe_valid, 1);
    exe_ready = 1'b1;
    tick();
    check_vec("bp_drain_pc1", exe_pc, 32'h104);
    check_vec("bp_drain_ready", id_ready, 1);
    tick();
    check_vec("bp_drain_pc2", exe_pc, 32'h108);
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check_vec("bp_empty", exe_valid, 0);

    // load-use
    exe_ready = 1'b0;
    offer(1'b1, 32'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    offer(1'b1, 32'h204, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0);
    exe_ready = 1'b1;
    #1;
    check_vec("lu_hazard", hazard_stall, 1);
    check_vec("lu_id_ready", id_ready, 0);
    tick();
    check_vec("lu_bubble_valid", exe_valid, 0);
    check_vec("lu_bubble_alu", exe_alu_ctrl, 0);
    check_vec("lu_bubble_dmw", exe_DM_write, 0);
    check_vec("lu_bubble_dmr", exe_DM_read, 0);
    check_vec("lu_cnt", bubble_cnt, 1);
    check_vec("lu_hazard_clr", hazard_stall, 0);
    tick();
    check_vec("lu_dep_valid", exe_valid, 1);
    check_vec("lu_dep_pc", exe_pc, 32'h204);
    check_vec("lu_cnt_hold", bubble_cnt, 1);
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();

    // no false hazard: rd=0, then unused rs2
    exe_ready = 1'b0;
    offer(1'b1, 32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    offer(1'b1, 32'h304, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0);
    #1;
    check_vec("nf_rd0_hazard", hazard_stall, 0);
    check_vec("nf_rd0_ready", id_ready, 1);
    tick();
    check_vec("nf_rd0_pc", exe_pc, 32'h300);
    exe_ready = 1'b1;
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check_vec("nf_skid_pc", exe_pc, 32'h304);
    tick();
    offer(1'b1, 32'h310, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    offer(1'b1, 32'h314, 5'd3, 1'b1, 5'd5, 1'b0, 5'd6, 1'b0);
    #1;
    check_vec("nf_rs2_hazard", hazard_stall, 0);
    check_vec("nf_rs2_ready", id_ready, 1);
    tick();
    check_vec("nf_rs2_valid", exe_valid, 1);
    check_vec("nf_rs2_pc", exe_pc, 32'h314);
    check_vec("nf_cnt", bubble_cnt, 1);
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();

    // flush in SKID state
    exe_ready = 1'b0;
    offer(1'b1, 32'h400, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    tick();
    offer(1'b1, 32'h404, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    tick();
    check_vec("fl_skid_ready", id_ready, 0);
    offer(1'b1, 32'h408, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check_vec("fl_exe_valid", exe_valid, 0);
    check_vec("fl_id_ready", id_ready, 1);
    exe_ready = 1'b1;
    tick();
    check_vec("fl_still_empty", exe_valid, 0);
    check_vec("fl_pc_hold", exe_pc, 32'h400);

    // mid-stream reset
    offer(1'b1, 32'h500, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    tick();
    check_vec("mr_valid_pre", exe_valid, 1);
    rst = 1'b0;
    #1;
    check_vec("mr_id_ready", id_ready, 0);
    tick();
    check_vec("mr_exe_valid", exe_valid, 0);
    check_vec("mr_exe_pc", exe_pc, 0);
    check_vec("mr_exe_reg1", exe_reg1, 0);
    check_vec("mr_cnt", bubble_cnt, 0);
    check_vec("mr_sat_cnt", s_bubble_cnt, 0);
    rst = 1'b1;
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();

    // saturation: 5 stall cycles
    exe_ready = 1'b0;
    offer(1'b1, 32'h600, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    offer(1'b1, 32'h604, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0);
    #1;
    check_vec("sat_hazard", hazard_stall, 1);
    repeat (5) tick();
    check_vec("sat_cnt16", bubble_cnt, 5);
    check_vec("sat_cnt2", s_bubble_cnt, 3);
    flush = 1'b1;
    #1;
    check_vec("sat_flush_hazard", hazard_stall, 0);
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check_vec("sat_flush_cnt", bubble_cnt, 5);
    check_vec("sat_flush_valid", exe_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
